// File: rtl/selector2_4_arbiter.sv
// Round-robin arbiter sharing one 4-bit two-input selector between two
// requesters, with a valid/ready handshake toward a single consumer.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no owner; s=0, waiting for a request
// GRANT0 | requester 0 owns y (s=0); its beats are acked on ack0
// GRANT1 | requester 1 owns y (s=1); its beats are acked on ack1
module selector2_4_arbiter #(
   parameter int MAX_BURST = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       req0,
   input  logic [3:0] d0,
   input  logic       req1,
   input  logic [3:0] d1,
   input  logic       y_ready,
   output logic       s,
   output logic [3:0] y,
   output logic       y_valid,
   output logic       ack0,
   output logic       ack1,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } state_t;

   localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);
   localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

   state_t     state, state_nxt;
   logic       last_owner, last_owner_nxt;
   logic [3:0] burst_cnt, burst_cnt_nxt;
   logic       own_req, other_req, xfer;
   state_t     other_grant;

   // Shared datapath: output follows the registered select line.
   assign y = s ? d1 : d0;

   // Owner-relative view of the requests and the handshake outputs.
   always_comb begin
      own_req     = 1'b0;
      other_req   = 1'b0;
      other_grant = IDLE;
      case (state)
         GRANT0: begin
            own_req     = req0;
            other_req   = req1;
            other_grant = GRANT1;
         end
         GRANT1: begin
            own_req     = req1;
            other_req   = req0;
            other_grant = GRANT0;
         end
         default: ;
      endcase
      xfer    = own_req & y_ready;
      y_valid = own_req;
      ack0    = (state == GRANT0) & xfer;
      ack1    = (state == GRANT1) & xfer;
   end

   // Next-state, burst counting and round-robin bookkeeping.
   always_comb begin
      state_nxt      = state;
      last_owner_nxt = last_owner;
      burst_cnt_nxt  = burst_cnt;
      case (state)
         IDLE: begin
            burst_cnt_nxt = 4'd0;
            if (req0 && req1)
               state_nxt = last_owner ? GRANT0 : GRANT1;
            else if (req0)
               state_nxt = GRANT0;
            else if (req1)
               state_nxt = GRANT1;
         end
         GRANT0, GRANT1: begin
            if (!own_req) begin
               // A dropped request (abort or end of data) hands over at once.
               state_nxt      = other_req ? other_grant : IDLE;
               burst_cnt_nxt  = 4'd0;
               last_owner_nxt = (state == GRANT1);
            end else if (xfer && burst_cnt == LAST_BEAT) begin
               // Burst limit only forces a handover when someone is waiting.
               burst_cnt_nxt = 4'd0;
               if (other_req) begin
                  state_nxt      = other_grant;
                  last_owner_nxt = (state == GRANT1);
               end
            end else if (xfer) begin
               burst_cnt_nxt = (burst_cnt == BURST_MAX) ? burst_cnt : burst_cnt + 4'd1;
            end
         end
         default: begin
            state_nxt     = IDLE;
            burst_cnt_nxt = 4'd0;
         end
      endcase
   end

   // State register; s and busy are registered from the next state so they
   // switch on the same edge as ownership and carry no path from y_ready.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         last_owner <= 1'b1;
         burst_cnt  <= 4'd0;
         s          <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_nxt;
         last_owner <= last_owner_nxt;
         burst_cnt  <= burst_cnt_nxt;
         s          <= (state_nxt == GRANT1);
         busy       <= (state_nxt != IDLE);
      end
   end

endmodule

// File: doc/selector2_4_arbiter.md
Name: selector2_4_arbiter

Overview:
Round-robin arbiter that shares one 4-bit 2-input selector datapath between two requesters.
- Decides which requester owns the shared 4-bit output y and drives the select line s.
- Each transferred beat is acknowledged to its owner.
- Sits between two 4-bit producers and one downstream consumer with a valid/ready handshake.
- Contains the selector function internally (y follows d0 or d1 per s).

Parameters:
- MAX_BURST, 4, maximum beats one requester may transfer while the other is waiting (range 1..15).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req0  input  1  requester 0 has data on d0.
- d0  input  4  requester 0 data.
- req1  input  1  requester 1 has data on d1.
- d1  input  4  requester 1 data.
- y_ready  input  1  consumer accepts y this cycle.
- s  output  1  select line (0 = d0, 1 = d1); registered.
- y  output  4  shared data = s ? d1 : d0 (combinational from s).
- y_valid  output  1  owner's req is high while granted.
- ack0  output  1  beat from requester 0 accepted this cycle.
- ack1  output  1  beat from requester 1 accepted this cycle.
- busy  output  1  state is not IDLE; registered.

Behaviour:
- Clock and reset: one clock, clk; reset_n is asynchronous and active-low.
- Reset (asynchronous, reset_n low): state=IDLE, s=0, last_owner=1 (so requester 0 wins the first tie), burst_cnt=0, busy=0. Consequently y_valid=0, ack0=ack1=0, y=d0.
- States: IDLE, GRANT0, GRANT1. In GRANTn, s=n and busy=1.
- IDLE transitions:
  - req0&~req1 -> GRANT0.
  - req1&~req0 -> GRANT1.
  - Both high -> GRANTk, where k = ~last_owner.
  - Neither -> stay in IDLE.
  - Arbitration latency is 1 cycle: y_valid can first go high the cycle after req rises.
- GRANTn outputs:
  - y_valid = reqn.
  - Transfer occurs when reqn & y_ready; then ackn=1 and burst_cnt increments (4-bit, saturating at MAX_BURST).
  - The non-owner ack is always 0.
- GRANTn exits, evaluated each cycle:
  - ~reqn and other req high -> GRANTother, burst_cnt=0, last_owner=n.
  - ~reqn and other req low -> IDLE, burst_cnt=0, last_owner=n.
  - Transfer completes the MAX_BURST-th beat and other req high -> GRANTother, burst_cnt=0, last_owner=n.
  - Transfer completes the MAX_BURST-th beat and other req low -> stay in GRANTn, burst_cnt=0 (unlimited ownership while uncontested).
  - Otherwise stay.
- Owner switches directly from GRANT0 to GRANT1 with no idle bubble. s changes on the same edge.
- Requester rules:
  - Must hold reqn and dn stable until ackn.
  - Dropping reqn without ack is a legal abort; no ack is issued.
- y_ready low stalls: state, s and burst_cnt are held; y_valid stays high while reqn is high.
- Simultaneous requester-drop and other-request: treated as a switch (first exit rule), never IDLE.
- reset_n asserted mid-burst: immediate return to reset values. Any in-flight beat is not acked.
- No combinational path from y_ready to s or busy.

Test Plan:
1. Reset: reset_n=0 with req0=req1=1, d0=4'h3, d1=4'hC -> s=0, y=4'h3, y_valid=0, busy=0. Release reset_n -> next edge GRANT0, y_valid=1.
2. Single requester: req1=1, d1=4'hA, y_ready=1, req0=0 -> after 1 cycle s=1, y=4'hA, ack1=1 every cycle. Stays GRANT1 beyond 4 beats (uncontested).
3. Fairness: req0=req1=1, y_ready=1 continuously, MAX_BURST=4 -> ack0 for 4 cycles, then ack1 for 4 cycles, alternating. s toggles every 4 cycles with no gap.
4. Backpressure: GRANT0, y_ready=0 for 3 cycles -> ack0=0, s=0, burst_cnt held. y_ready=1 -> ack0=1, count resumes.
5. Abort/switch: GRANT0 after 2 beats, req0 drops while req1=1 -> next edge s=1, burst_cnt=0. Then req1 drops with req0=0 -> IDLE, busy=0.
6. Mid-burst reset: GRANT1 with burst_cnt=3, pulse reset_n low asynchronously (between edges) -> s=0, busy=0, ack1=0 immediately. After release, a tie grants requester 0.
